// File: rtl/trace_packet_builder_pkg.sv
// Shared types and packet layout helpers for the retirement trace packet builder.
package trace_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRACING = 2'd2,
        STOPPED = 2'd3
    } trace_state_e;

    localparam int DROP_W = 16;
    localparam int TS_W   = 32;

    // Field offsets, LSB first: event counts, instruction, PC, sequence, timestamp.
    function automatic int instr_off(int ne, int cw);
        return ne * cw;
    endfunction

    function automatic int pc_off(int ne, int cw, int iw);
        return ne * cw + iw;
    endfunction

    function automatic int seq_off(int ne, int cw, int iw, int pw);
        return ne * cw + iw + pw;
    endfunction

    function automatic int ts_off(int ne, int cw, int iw, int pw, int sw);
        return ne * cw + iw + pw + sw;
    endfunction
endpackage

// File: rtl/trace_packet_builder_if.sv
// Retirement trace input and packet-sink write port of the trace packet builder.
interface trace_packet_builder_if #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int NUM_EVENTS  = 16,
    parameter int DATA_WIDTH  = 1024
);
    logic                   i_valid;
    logic [PC_WIDTH-1:0]    i_pc;
    logic [INSTR_WIDTH-1:0] i_instr;
    logic [NUM_EVENTS-1:0]  i_events;
    logic                   sink_ready;
    logic                   write_enable;
    logic [DATA_WIDTH-1:0]  data_pkt;

    modport master (output i_valid, i_pc, i_instr, i_events, sink_ready,
                    input  write_enable, data_pkt);
    modport slave  (input  i_valid, i_pc, i_instr, i_events, sink_ready,
                    output write_enable, data_pkt);
endinterface

// File: rtl/trace_packet_builder_event_counter_bank.sv
// Bank of saturating per-event counters; snapshot folds in the current cycle's pulses.
module event_counter_bank #(
    parameter int NUM_EVENTS = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  acc_en,
    input  logic                                  clr,
    input  logic [NUM_EVENTS-1:0]                 pulses,
    output logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0]  snapshot
);
    logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] cnt;

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cnt
        assign snapshot[g] = (cnt[g] == '1) ? cnt[g] : cnt[g] + CNT_WIDTH'(pulses[g]);

        always_ff @(posedge clk) begin
            if (!rst_n || clr || !acc_en) cnt[g] <= '0;
            else                          cnt[g] <= snapshot[g];
        end
    end
endmodule

// File: rtl/trace_packet_builder.sv
// Address-triggered retirement trace packetiser; drops (and counts) packets under backpressure.
// Define TRACE_PKT_TIMESTAMP_EN to fill the timestamp field from a free-running cycle counter.
module trace_packet_builder
    import trace_pkg::*;
#(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int NUM_EVENTS  = 16,
    parameter int CNT_WIDTH   = 8,
    parameter int SEQ_WIDTH   = 16,
    parameter int DATA_WIDTH  = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ctrl_enable,
    input  logic                trigger_en,
    input  logic [PC_WIDTH-1:0] trigger_start_addr,
    input  logic [PC_WIDTH-1:0] trigger_stop_addr,
    trace_packet_builder_if.slave bus,
    output logic [1:0]          state,
    output logic [DROP_W-1:0]   drop_count
);
    localparam int INSTR_OFF = instr_off(NUM_EVENTS, CNT_WIDTH);
    localparam int PC_OFF    = pc_off(NUM_EVENTS, CNT_WIDTH, INSTR_WIDTH);
    localparam int SEQ_OFF   = seq_off(NUM_EVENTS, CNT_WIDTH, INSTR_WIDTH, PC_WIDTH);
    localparam int TS_OFF    = ts_off(NUM_EVENTS, CNT_WIDTH, INSTR_WIDTH, PC_WIDTH, SEQ_WIDTH);

    trace_state_e st, st_nxt;
    logic traced, emit, drop, acc_en, start_hit, stop_hit;
    logic [SEQ_WIDTH-1:0] seq;
    logic [TS_W-1:0] ts;
    logic [DATA_WIDTH-1:0] pkt;
    logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] snapshot;

    assign start_hit = bus.i_valid && (bus.i_pc == trigger_start_addr);
    assign stop_hit  = bus.i_valid && (bus.i_pc == trigger_stop_addr) && trigger_en;

    always_comb begin
        st_nxt = st;
        traced = 1'b0;
        if (!ctrl_enable) begin
            st_nxt = IDLE;
        end else begin
            case (st)
                IDLE:    st_nxt = trigger_en ? ARMED : TRACING;
                ARMED:   if (start_hit) begin
                             traced = 1'b1;
                             st_nxt = stop_hit ? STOPPED : TRACING;
                         end
                TRACING: if (bus.i_valid) begin
                             traced = 1'b1;
                             if (stop_hit) st_nxt = STOPPED;
                         end
                default: ;
            endcase
        end
    end

    assign emit = traced && bus.sink_ready;
    assign drop = traced && !bus.sink_ready;
    // A dropped start match keeps its events so the next accepted packet spans them.
    assign acc_en = (st_nxt == TRACING) && ((st == TRACING) || traced);

    event_counter_bank #(.NUM_EVENTS(NUM_EVENTS), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .acc_en   (acc_en),
        .clr      (emit),
        .pulses   (bus.i_events),
        .snapshot (snapshot)
    );

`ifdef TRACE_PKT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 1'b1;
    end
    assign ts = ts_cnt;
`else
    assign ts = '0;
`endif

    always_comb begin
        pkt = '0;
        pkt[0 +: NUM_EVENTS*CNT_WIDTH] = snapshot;
        pkt[INSTR_OFF +: INSTR_WIDTH]  = bus.i_instr;
        pkt[PC_OFF +: PC_WIDTH]        = bus.i_pc;
        pkt[SEQ_OFF +: SEQ_WIDTH]      = seq;
        pkt[TS_OFF +: TS_W]            = ts;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st               <= IDLE;
            bus.write_enable <= 1'b0;
            bus.data_pkt     <= '0;
            seq              <= '0;
            drop_count       <= '0;
        end else begin
            st               <= st_nxt;
            bus.write_enable <= emit;
            if (emit) begin
                bus.data_pkt <= pkt;
                seq          <= seq + 1'b1;
            end
            if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    assign state = st;
endmodule
